wb_stage: RTL and testbench

- Write-back stage of the 5-stage MIPS core; sits directly downstream of the data memory and the MEM stage.
- Contains the MEM/WB pipeline register and load-data extraction/extension for lw/lb/lbu/lh/lhu.
- Contains the write-data select and the 32x32 general register file, with same-cycle write-to-read bypass for the decode stage.
- Exports the WB write triple so the hazard unit can forward it.

---
 rtl/wb_stage_pkg.sv | 72 +++++++
 rtl/wb_stage_if.sv | 41 ++++
 rtl/wb_stage_grf.sv | 81 ++++++++
 rtl/wb_stage.sv | 83 ++++++++
 tb/tb_wb_stage.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the MIPS write-back stage.
//   - load-type codes (LD_*) carried on mem_ld_type
//   - write-data select codes (WD_*) carried on mem_wd_sel
//   - register-zero constant and the MEM/WB pipeline record
//   - load_extend(): byte/halfword extraction and sign/zero extension
package wb_stage_pkg;

  localparam int DW_C   = 32;
  localparam int AW_C   = 5;
  localparam int NREG_C = 32;

  localparam logic [AW_C-1:0] REG_ZERO = 5'd0;

  // Codes 5..7 are not named and fall through to the word path.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_BU = 3'd1,
    LD_B  = 3'd2,
    LD_HU = 3'd3,
    LD_H  = 3'd4
  } ld_type_e;

  // Code 3 is a second encoding of the ALU result.
  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_MEM  = 2'd1,
    WD_PC8  = 2'd2,
    WD_ALU3 = 2'd3
  } wd_sel_e;

  // Contents of the MEM/WB pipeline register; all-zero is a bubble.
  typedef struct packed {
    logic            valid;
    logic [DW_C-1:0] pc;
    logic [DW_C-1:0] alu_out;
    logic [DW_C-1:0] dm_out;
    logic            reg_write;
    logic [AW_C-1:0] wa;
    logic [1:0]      wd_sel;
    logic [2:0]      ld_type;
  } memwb_t;

  // Pick the addressed byte/halfword out of an aligned word and extend it.
  // For halfwords only off[1] matters; a misaligned halfword is not trapped.
  function automatic logic [DW_C-1:0] load_extend(input logic [2:0]      ld_type,
                                                  input logic [1:0]      off,
                                                  input logic [DW_C-1:0] word);
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [DW_C-1:0] res_v;
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    if (off[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (ld_type_e'(ld_type))
      LD_BU:   res_v = {24'd0, byte_v};
      LD_B:    res_v = {{24{byte_v[7]}}, byte_v};
      LD_HU:   res_v = {16'd0, half_v};
      LD_H:    res_v = {{16{half_v[15]}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: bundle between the MEM stage / decode stage / hazard unit and
// the write-back stage.
//   MEM side : flush, mem_valid, mem_pc, mem_alu_out, mem_dm_out,
//              mem_reg_write, mem_wa, mem_wd_sel, mem_ld_type
//   decode   : rs_addr, rt_addr -> rs_data, rt_data
//   forward  : wb_we, wb_wa, wb_wd (the write triple seen by the hazard unit)
// master = the surrounding pipeline, slave = wb_stage.
interface wb_stage_if #(
  parameter int DW = 32
);
  logic          flush;
  logic          mem_valid;
  logic [DW-1:0] mem_pc;
  logic [DW-1:0] mem_alu_out;
  logic [DW-1:0] mem_dm_out;
  logic          mem_reg_write;
  logic [4:0]    mem_wa;
  logic [1:0]    mem_wd_sel;
  logic [2:0]    mem_ld_type;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          wb_we;
  logic [4:0]    wb_wa;
  logic [DW-1:0] wb_wd;

  modport master (
    output flush, mem_valid, mem_pc, mem_alu_out, mem_dm_out,
           mem_reg_write, mem_wa, mem_wd_sel, mem_ld_type,
           rs_addr, rt_addr,
    input  rs_data, rt_data, wb_we, wb_wa, wb_wd
  );

  modport slave (
    input  flush, mem_valid, mem_pc, mem_alu_out, mem_dm_out,
           mem_reg_write, mem_wa, mem_wd_sel, mem_ld_type,
           rs_addr, rt_addr,
    output rs_data, rt_data, wb_we, wb_wa, wb_wd
  );
endinterface

// File: rtl/wb_stage_grf.sv
// wb_stage_grf: 32x32 general register file.
//   clk, reset       : clock, synchronous active-high clear of every entry
//   we, wa, wd, pc   : write port (pc only feeds the write trace)
//   rs_addr/rs_data,
//   rt_addr/rt_data  : combinational read ports with same-cycle bypass of
//                      the write port, so decode sees the value being
//                      written this cycle.
module wb_stage_grf
  import wb_stage_pkg::*;
#(
  parameter int NREG = NREG_C,
  parameter int DW   = DW_C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [DW-1:0]   wd,
  input  logic [DW-1:0]   pc,
  input  logic [4:0]      rs_addr,
  input  logic [4:0]      rt_addr,
  output logic [DW-1:0]   rs_data,
  output logic [DW-1:0]   rt_data
);

  logic [DW-1:0] regs_r [NREG];
  logic          wr_en_s;
  logic [DW-1:0] rs_data_s;
  logic [DW-1:0] rt_data_s;

  // $0 is re-masked here so no caller can ever make it non-zero.
  assign wr_en_s = we && (wa != REG_ZERO);

  // Register array: clear on reset, otherwise apply the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[wa] <= wd;
    end
  end

`ifndef SYNTHESIS
  // Simulation trace of every committed register write.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_s) begin
      $display("@%h: $%d <= %h", pc, wa, wd);
    end
  end
`endif

  // Read port A: zero register, then write bypass, then array.
  always_comb begin
    rs_data_s = '0;
    if (rs_addr == REG_ZERO) begin
      rs_data_s = '0;
    end else if (wr_en_s && (rs_addr == wa)) begin
      rs_data_s = wd;
    end else begin
      rs_data_s = regs_r[rs_addr];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rt_data_s = '0;
    if (rt_addr == REG_ZERO) begin
      rt_data_s = '0;
    end else if (wr_en_s && (rt_addr == wa)) begin
      rt_data_s = wd;
    end else begin
      rt_data_s = regs_r[rt_addr];
    end
  end

  assign rs_data = rs_data_s;
  assign rt_data = rt_data_s;

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage MIPS core.
//   clk, reset : clock, synchronous active-high reset (beats flush and writes)
//   bus        : wb_stage_if slave port
//     in  : flush, mem_* (MEM-stage instruction), rs_addr, rt_addr
//     out : rs_data, rt_data (decode reads), wb_we/wb_wa/wb_wd (write triple)
// The MEM/WB register latches the MEM instruction (or a bubble on flush);
// load extension and the write-data mux run combinationally off that
// register, and the result is committed to the GRF on the following edge.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int NREG = NREG_C,
  parameter int DW   = DW_C
) (
  input  logic     clk,
  input  logic     reset,
  wb_stage_if.slave bus
);

  memwb_t        memwb_r;
  logic [DW-1:0] ld_data_s;
  logic [DW-1:0] pc8_s;
  logic [DW-1:0] wd_s;
  logic          we_s;

  // MEM/WB pipeline register; flush and reset both load an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_r <= '0;
    end else if (bus.flush) begin
      memwb_r <= '0;
    end else begin
      memwb_r.valid     <= bus.mem_valid;
      memwb_r.pc        <= bus.mem_pc;
      memwb_r.alu_out   <= bus.mem_alu_out;
      memwb_r.dm_out    <= bus.mem_dm_out;
      memwb_r.reg_write <= bus.mem_reg_write;
      memwb_r.wa        <= bus.mem_wa;
      memwb_r.wd_sel    <= bus.mem_wd_sel;
      memwb_r.ld_type   <= bus.mem_ld_type;
    end
  end

  assign ld_data_s = load_extend(memwb_r.ld_type, memwb_r.alu_out[1:0],
                                 memwb_r.dm_out);
  // Link address wraps naturally at 2^32.
  assign pc8_s = memwb_r.pc + 32'd8;

  // Write-data select.
  always_comb begin
    wd_s = memwb_r.alu_out;
    case (wd_sel_e'(memwb_r.wd_sel))
      WD_ALU:  wd_s = memwb_r.alu_out;
      WD_MEM:  wd_s = ld_data_s;
      WD_PC8:  wd_s = pc8_s;
      default: wd_s = memwb_r.alu_out;
    endcase
  end

  // Bubbles and $0 destinations never produce a visible write.
  assign we_s = memwb_r.valid && memwb_r.reg_write && (memwb_r.wa != REG_ZERO);

  wb_stage_grf #(
    .NREG (NREG),
    .DW   (DW)
  ) u_grf (
    .clk     (clk),
    .reset   (reset),
    .we      (we_s),
    .wa      (memwb_r.wa),
    .wd      (wd_s),
    .pc      (memwb_r.pc),
    .rs_addr (bus.rs_addr),
    .rt_addr (bus.rt_addr),
    .rs_data (bus.rs_data),
    .rt_data (bus.rt_data)
  );

  assign bus.wb_we = we_s;
  assign bus.wb_wa = memwb_r.wa;
  assign bus.wb_wd = wd_s;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic clk;
  logic reset;
  int   err_cnt;
  int   chk_cnt;

  wb_stage_if #(.DW(32)) bus ();

  wb_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.flush         = 1'b0;
    bus.mem_valid     = 1'b0;
    bus.mem_pc        = 32'd0;
    bus.mem_alu_out   = 32'd0;
    bus.mem_dm_out    = 32'd0;
    bus.mem_reg_write = 1'b0;
    bus.mem_wa        = 5'd0;
    bus.mem_wd_sel    = 2'd0;
    bus.mem_ld_type   = 3'd0;
  endtask

  // Present one MEM instruction, clock it into MEM/WB, then go idle.
  task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dm, input logic rw, input logic [4:0] wa,
                       input logic [1:0] sel, input logic [2:0] ld, input logic fl);
    bus.flush         = fl;
    bus.mem_valid     = v;
    bus.mem_pc        = pc;
    bus.mem_alu_out   = alu;
    bus.mem_dm_out    = dm;
    bus.mem_reg_write = rw;
    bus.mem_wa        = wa;
    bus.mem_wd_sel    = sel;
    bus.mem_ld_type   = ld;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic idle_cycle();
    set_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_rs(input logic [4:0] a, input string tag, input logic [31:0] exp);
    bus.rs_addr = a;
    #1;
    check_val(tag, bus.rs_data, exp);
  endtask

  // Load-extension vector: dm word 0x80FF7F01 into $10.
  task automatic ext_case(input string tag, input logic [31:0] alu,
                          input logic [2:0] ld, input logic [31:0] exp);
    issue(1'b1, 32'h0040_0100, alu, 32'h80FF_7F01, 1'b1, 5'd10, 2'd1, ld, 1'b0);
    check_val(tag, bus.wb_wd, exp);
  endtask

  initial begin
    err_cnt     = 0;
    chk_cnt     = 0;
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;

    // Reset while the MEM side drives a live write.
    reset = 1'b1;
    issue(1'b1, 32'h0040_0000, 32'h1111_1111, 32'h2222_2222, 1'b1, 5'd5, 2'd1, 3'd0, 1'b0);
    check_val("rst_we", {31'd0, bus.wb_we}, 32'd0);
    check_val("rst_wd", bus.wb_wd, 32'd0);
    check_val("rst_wa", {27'd0, bus.wb_wa}, 32'd0);
    read_rs(5'd5, "rst_rs5", 32'd0);
    reset = 1'b0;
    idle_cycle();

    // lw into $8, bypass on both ports, then array read.
    issue(1'b1, 32'h0040_0004, 32'h1001_0000, 32'h1234_5678, 1'b1, 5'd8, 2'd1, 3'd0, 1'b0);
    check_val("lw_we", {31'd0, bus.wb_we}, 32'd1);
    check_val("lw_wa", {27'd0, bus.wb_wa}, 32'd8);
    check_val("lw_wd", bus.wb_wd, 32'h1234_5678);
    bus.rt_addr = 5'd8;
    read_rs(5'd8, "lw_byp_rs", 32'h1234_5678);
    check_val("lw_byp_rt", bus.rt_data, 32'h1234_5678);
    idle_cycle();
    check_val("idle_we", {31'd0, bus.wb_we}, 32'd0);
    read_rs(5'd8, "lw_arr", 32'h1234_5678);

    // Byte / halfword extraction and extension.
    ext_case("lb_off3",  32'h1001_0003, 3'd2, 32'hFFFF_FF80);
    ext_case("lbu_off3", 32'h1001_0003, 3'd1, 32'h0000_0080);
    ext_case("lh_off2",  32'h1001_0002, 3'd4, 32'hFFFF_80FF);
    ext_case("lhu_off2", 32'h1001_0002, 3'd3, 32'h0000_80FF);
    ext_case("lb_off0",  32'h1001_0000, 3'd2, 32'h0000_0001);
    ext_case("lb_off1",  32'h1001_0001, 3'd2, 32'h0000_007F);
    ext_case("lbu_off2", 32'h1001_0002, 3'd1, 32'h0000_00FF);
    ext_case("lh_off3",  32'h1001_0003, 3'd4, 32'hFFFF_80FF);
    ext_case("lhu_off0", 32'h1001_0000, 3'd3, 32'h0000_7F01);
    ext_case("lh_off1",  32'h1001_0001, 3'd4, 32'h0000_7F01);
    ext_case("ld5_is_lw", 32'h1001_0002, 3'd5, 32'h80FF_7F01);
    idle_cycle();
    read_rs(5'd10, "ext_arr", 32'h80FF_7F01);

    // Write to $0 is dropped.
    issue(1'b1, 32'h0040_0200, 32'hDEAD_BEEF, 32'd0, 1'b1, 5'd0, 2'd0, 3'd0, 1'b0);
    check_val("z_we", {31'd0, bus.wb_we}, 32'd0);
    check_val("z_wd", bus.wb_wd, 32'hDEAD_BEEF);
    read_rs(5'd0, "z_rs0", 32'd0);
    idle_cycle();
    read_rs(5'd0, "z_rs0_arr", 32'd0);

    // Flushed and invalid writes to $9 have no effect.
    issue(1'b1, 32'h0040_0300, 32'h0000_0099, 32'd0, 1'b1, 5'd9, 2'd0, 3'd0, 1'b1);
    check_val("fl_we", {31'd0, bus.wb_we}, 32'd0);
    idle_cycle();
    read_rs(5'd9, "fl_rs9", 32'd0);
    issue(1'b0, 32'h0040_0300, 32'h0000_0099, 32'd0, 1'b1, 5'd9, 2'd0, 3'd0, 1'b0);
    check_val("nv_we", {31'd0, bus.wb_we}, 32'd0);
    idle_cycle();
    read_rs(5'd9, "nv_rs9", 32'd0);

    // ALU write to $9, dual bypass.
    issue(1'b1, 32'h0040_0304, 32'h0000_0099, 32'd0, 1'b1, 5'd9, 2'd3, 3'd0, 1'b0);
    bus.rt_addr = 5'd9;
    read_rs(5'd9, "alu_byp_rs", 32'h0000_0099);
    check_val("alu_byp_rt", bus.rt_data, 32'h0000_0099);

    // Back-to-back writes to $11: later value wins.
    issue(1'b1, 32'h0040_0400, 32'h0000_0001, 32'd0, 1'b1, 5'd11, 2'd0, 3'd0, 1'b0);
    issue(1'b1, 32'h0040_0404, 32'h0000_0002, 32'd0, 1'b1, 5'd11, 2'd0, 3'd0, 1'b0);
    read_rs(5'd11, "b2b_byp", 32'h0000_0002);
    idle_cycle();
    read_rs(5'd11, "b2b_arr", 32'h0000_0002);

    // Reset with a write to $3 pending in MEM/WB.
    issue(1'b1, 32'h0040_0500, 32'h0000_0033, 32'd0, 1'b1, 5'd3, 2'd0, 3'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("mr_we", {31'd0, bus.wb_we}, 32'd0);
    read_rs(5'd3, "mr_rs3", 32'd0);
    read_rs(5'd8, "mr_rs8_clr", 32'd0);

    // pc+8 wraps modulo 2^32 after reset is released.
    issue(1'b1, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1, 5'd4, 2'd2, 3'd0, 1'b0);
    check_val("pc8_wd", bus.wb_wd, 32'h0000_0004);
    check_val("pc8_we", {31'd0, bus.wb_we}, 32'd1);
    idle_cycle();
    read_rs(5'd4, "pc8_arr", 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
